// File: rtl/status_report_packer.sv
// Buffers time-stamped status records from the channel arbiter and streams
// each one as two 32-bit report words: packed fields, then capture timestamp.
module status_report_packer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  output logic          status_idle_o,
  input  logic          status_ack_i,
  input  logic          status_ack_type_i,
  input  logic [8:0]    status_VR_id_i,
  input  logic [2:0]    status_VR_FR_i,
  input  logic [4:0]    status_channel_ID_i,
  input  logic [7:0]    status_pos_1st_i,
  input  logic [2:0]    status_pos_2nd_i,
  input  logic [1:0]    status_src_type_i,
  output logic          rpt_valid_o,
  output logic [31:0]   rpt_data_o,
  output logic          rpt_last_o,
  input  logic          rpt_ready_i,
  output logic [AW:0]   fifo_level_o,
  output logic          err_ovf_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, W0, W1} state_t;

  // Entry layout: {timestamp[31:0], fields[30:0]}; fields are word0 without its zero LSB.
  logic [62:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   level_reg, level_next;
  logic [31:0]   ts_reg, ts_hold_reg;
  logic [31:0]   data_reg;
  logic          idle_reg, valid_reg, last_reg, err_reg;
  state_t        state_reg, state_next;
  logic          push, pop, load0, load1, drop;
  logic [62:0]   head;
  logic [30:0]   fields;

  assign fields = {status_ack_type_i, status_src_type_i, status_pos_2nd_i,
                   status_VR_FR_i, status_channel_ID_i, status_VR_id_i,
                   status_pos_1st_i};
  assign head   = mem[rd_ptr_reg];
  assign push   = status_ack_i && (level_reg != DEPTH_L);
  assign level_next = level_reg + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load0      = 1'b0;
    load1      = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          load0      = 1'b1;
          state_next = W0;
        end
      end
      W0: begin
        if (valid_reg && rpt_ready_i) begin
          load1      = 1'b1;
          state_next = W1;
        end
      end
      W1: begin
        if (valid_reg && rpt_ready_i) begin
          if (level_reg != '0) begin
            // Next record follows its predecessor's last word with no bubble.
            pop        = 1'b1;
            load0      = 1'b1;
            state_next = W0;
          end else begin
            drop       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {ts_reg, fields};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ts_reg      <= '0;
      ts_hold_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      state_reg   <= IDLE;
      idle_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      last_reg    <= 1'b0;
      data_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      ts_reg    <= ts_reg + 32'd1;
      state_reg <= state_next;
      level_reg <= level_next;
      // Dropping idle after each ack re-arms the arbiter's idle-protect.
      idle_reg  <= !status_ack_i && (level_next < DEPTH_L);
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (status_ack_i && (level_reg == DEPTH_L)) begin
        err_reg <= 1'b1;
      end
      if (load0) begin
        data_reg    <= {head[30:0], 1'b0};
        ts_hold_reg <= head[62:31];
        valid_reg   <= 1'b1;
        last_reg    <= 1'b0;
      end else if (load1) begin
        data_reg <= ts_hold_reg;
        last_reg <= 1'b1;
      end else if (drop) begin
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
      end
    end
  end

  assign status_idle_o = idle_reg;
  assign rpt_valid_o   = valid_reg;
  assign rpt_data_o    = data_reg;
  assign rpt_last_o    = last_reg;
  assign fifo_level_o  = level_reg;
  assign err_ovf_o     = err_reg;

endmodule
